// File: rtl/move_ctrl_if.sv
// Request/board/status bundle for the turn and move controller.
// master drives requests and board state; slave is move_ctrl itself.
interface move_ctrl_if #(
    parameter int COORD_W = 3,
    parameter int CNT_W   = 6
);
    // player side
    logic               place;
    logic               new_game;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    // board side
    logic [1:0]         state;
    logic               go;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               color;
    logic               board_clr_n;
    // status
    logic               illegal;
    logic               game_over;
    logic [1:0]         winner;
    logic [CNT_W-1:0]   move_count;

    modport master (
        output place, new_game, req_x, req_y, state,
        input  go, x, y, color, board_clr_n,
        input  illegal, game_over, winner, move_count
    );

    modport slave (
        input  place, new_game, req_x, req_y, state,
        output go, x, y, color, board_clr_n,
        output illegal, game_over, winner, move_count
    );
endinterface

// File: rtl/move_ctrl.sv
// Turn/move controller upstream of the board: validates moves, alternates
// sides, issues board loads, clears the board, and judges win or draw.
// Ports: clk, resetn (async active-low), bus (move_ctrl_if.slave):
//   place/new_game/req_x/req_y/state in; go/x/y/color/board_clr_n,
//   illegal/game_over/winner/move_count out (all registered).
module move_ctrl #(
    parameter int BOARD_N = 7,
    parameter int COORD_W = 3,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        resetn,
    move_ctrl_if.slave  bus
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam logic [CNT_W-1:0]   FULL = CNT_W'(CELLS);
    localparam logic [COORD_W:0]   LIM  = (COORD_W + 1)'(BOARD_N);
    localparam logic [CNT_W-1:0]   SIDE = CNT_W'(BOARD_N);

    localparam logic [1:0] WIN_NONE  = 2'd0;
    localparam logic [1:0] WIN_BLACK = 2'd1;
    localparam logic [1:0] WIN_WHITE = 2'd2;
    localparam logic [1:0] WIN_DRAW  = 2'd3;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_CHECK,
        S_COMMIT,
        S_EVAL,
        S_OVER
    } state_e;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               color_q, color_d;
    logic               go_q, go_d;
    logic               clr_n_q, clr_n_d;
    logic               illegal_q, illegal_d;
    logic               over_q, over_d;
    logic [1:0]         winner_q, winner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CELLS-1:0]   occ_q, occ_d;

    logic [CNT_W-1:0]   cell_idx;
    logic               out_of_range;
    logic               bad_req;

    // Row-major cell index; only meaningful when the coordinate is in range.
    assign cell_idx = CNT_W'(x_q) * SIDE + CNT_W'(y_q);

    assign out_of_range = ({1'b0, x_q} >= LIM) || ({1'b0, y_q} >= LIM);

    // Range is checked first so an out-of-range index never matters.
    assign bad_req = out_of_range || occ_q[cell_idx];

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        occ_d     = occ_q;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        over_d    = over_q;
        illegal_d = 1'b0;

        if (bus.new_game) begin
            // Restart wins over everything, including an in-flight move.
            state_d = S_CLEAR;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    occ_d    = '0;
                    cnt_d    = '0;
                    color_d  = 1'b0;
                    winner_d = WIN_NONE;
                    over_d   = 1'b0;
                    state_d  = S_IDLE;
                end
                S_IDLE: begin
                    if (bus.place) begin
                        x_d     = bus.req_x;
                        y_d     = bus.req_y;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad_req) begin
                        illegal_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    occ_d[cell_idx] = 1'b1;
                    if (cnt_q != FULL) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = S_EVAL;
                end
                S_EVAL: begin
                    // Board has absorbed the load; its win state is valid.
                    if (bus.state == WIN_BLACK || bus.state == WIN_WHITE) begin
                        winner_d = bus.state;
                        over_d   = 1'b1;
                        state_d  = S_OVER;
                    end else if (cnt_q == FULL) begin
                        winner_d = WIN_DRAW;
                        over_d   = 1'b1;
                        state_d  = S_OVER;
                    end else begin
                        color_d = ~color_q;
                        state_d = S_IDLE;
                    end
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: begin
                    state_d = S_CLEAR;
                end
            endcase
        end

        // Strobes are registered from the next state so they are flop
        // outputs aligned exactly with the state they belong to.
        go_d    = (state_d == S_COMMIT);
        clr_n_d = (state_d != S_CLEAR);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_CLEAR;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= 1'b0;
            go_q      <= 1'b0;
            clr_n_q   <= 1'b0;
            illegal_q <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= WIN_NONE;
            cnt_q     <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
            go_q      <= go_d;
            clr_n_q   <= clr_n_d;
            illegal_q <= illegal_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
            cnt_q     <= cnt_d;
            occ_q     <= occ_d;
        end
    end

    assign bus.go          = go_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.color       = color_q;
    assign bus.board_clr_n = clr_n_q;
    assign bus.illegal     = illegal_q;
    assign bus.game_over   = over_q;
    assign bus.winner      = winner_q;
    assign bus.move_count  = cnt_q;

endmodule

// File: doc/move_ctrl.md
Name: move_ctrl

Overview:
- Turn/move controller sitting directly upstream of the board stage.
- Accepts player move requests (row, col strobe), rejects illegal ones, alternates black/white, and issues the single-cycle load (go, x, y, color) to the board.
- Samples the board's win state after each load and declares win or draw.
- Owns the board's clear strobe at reset and new game.

Parameters:
- BOARD_N, 7, board side length; legal coordinates are 0..BOARD_N-1.
- COORD_W, 3, coordinate width in bits.
- CNT_W, 6, move counter width; must hold BOARD_N*BOARD_N.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- place  in  1  single-cycle move request strobe, debounced upstream.
- new_game  in  1  single-cycle restart strobe.
- req_x  in  COORD_W  requested row.
- req_y  in  COORD_W  requested column.
- state  in  2  board win state: 0 none, 1 black win, 2 white win; combinational from board contents.
- go  out  1  board load strobe.
- x  out  COORD_W  row to load.
- y  out  COORD_W  column to load.
- color  out  1  side to move: 0 black, 1 white.
- board_clr_n  out  1  active-low board clear, one cycle.
- illegal  out  1  one-cycle reject pulse.
- game_over  out  1  level; high once the game has ended.
- winner  out  2  0 none, 1 black, 2 white, 3 draw.
- move_count  out  CNT_W  accepted moves this game.

Behaviour:
- All state is clocked on posedge clk, with async clear on resetn low.
- Reset values: go=0, x=0, y=0, color=0, board_clr_n=0, illegal=0, game_over=0, winner=0, move_count=0, occupancy map all 0, FSM=CLEAR.
- FSM states: CLEAR, IDLE, CHECK, COMMIT, EVAL, OVER.
- CLEAR:
  - board_clr_n=0 for exactly this cycle.
  - Zero the occupancy map, move_count, color, winner and game_over.
  - Next state is IDLE.
- IDLE:
  - On place=1, latch req_x/req_y into x/y, then go to CHECK.
  - With place=0, stay in IDLE.
- CHECK:
  - Illegal if x>=BOARD_N, y>=BOARD_N, or occupancy[x][y]=1.
  - Illegal: illegal=1 on the next cycle only, return to IDLE, color and count unchanged.
  - Legal: go to COMMIT.
- COMMIT:
  - go=1 for exactly this cycle, decoded from the state register (glitch-free).
  - Set occupancy[x][y]; move_count +1.
  - Next state is EVAL.
- EVAL:
  - The board has absorbed the load, so state is now valid.
  - state=1 or 2: winner=state, game_over=1, go to OVER.
  - Else, move_count==BOARD_N*BOARD_N: winner=3, game_over=1, go to OVER.
  - Else: toggle color, go to IDLE.
  - state=3 is treated as no win.
- OVER: place is ignored (no illegal pulse); hold all outputs until new_game.
- Latency: place sampled in cycle n gives go high in cycle n+2. State is sampled in n+3; the next place is accepted from n+4.
- place outside IDLE is dropped silently; there is no queuing.
- x/y and color are stable from CHECK through EVAL; the board sees them valid with go.
- new_game=1 in any state moves to CLEAR next cycle, has priority over place, and aborts an in-flight move. An abort in COMMIT still emits that go, and CLEAR wipes it.
- Async reset mid-game: immediate return to reset values; CLEAR runs on the first clock after deassertion, so the board is always cleared after reset.
- move_count saturates at BOARD_N*BOARD_N; it cannot exceed it because a full board ends the game.

Test Plan:
- Reset release, then idle: board_clr_n=0 in the first cycle then 1, IDLE, color=0, move_count=0, go never asserted.
- place (3,3) at cycle n: go=1 only at n+2 with x=3, y=3, color=0. At n+3 with state=0: color becomes 1, move_count=1.
- Occupied or out-of-range request: second place at (3,3), and place at (7,0): each gives illegal=1 for one cycle, no go, color and count unchanged.
- Black win: alternate moves until black fills (3,1)..(3,5); bench drives state=1 in EVAL, so game_over=1, winner=1. A following place yields no go and no illegal.
- Draw: 49 legal moves with state held 0: after the 49th EVAL, winner=3, game_over=1, move_count=49.
- new_game in the same cycle as place while in IDLE: CLEAR next cycle (board_clr_n=0), no go. The next place is committed with color=0 and move_count=1.
